// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-read arbiter.
// Optional feature macro used by this slice: SD_ARB_ROUND_ROBIN_EN.
package sd_arb_pkg;

  localparam int unsigned SD_SECTOR_BYTES = 512;
  localparam int unsigned SD_ADDR_W       = 9;

  typedef enum logic [2:0] {
    ARB   = 3'd0,
    ISSUE = 3'd1,
    WBUSY = 3'd2,
    WDONE = 3'd3,
    NEXT  = 3'd4
  } sd_arb_state_t;

endpackage

// File: rtl/sd_arb_picker.sv
// Request picker: one-hot winner and its id over a request vector.
// SD_ARB_ROUND_ROBIN_EN builds a rotating-priority pointer; otherwise lowest index wins.
module sd_arb_picker
  import sd_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_take,
  output logic [NREQ-1:0] o_win,
  output logic [IDW-1:0]  o_id,
  output logic            o_any
);

`ifdef SD_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_j;
  logic           w_found;

  // Search starts at r_ptr, the index after the last granted requester.
  always_comb begin
    o_win   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_j = IDW'((32'(r_ptr) + i) % NREQ);
      if (!w_found && i_req[w_j]) begin
        o_win[w_j] = 1'b1;
        o_id       = w_j;
        w_found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_take) begin
      r_ptr <= (o_id == IDW'(NREQ - 1)) ? '0 : o_id + 1'b1;
    end
  end
`else
  logic w_found;
  logic w_unused;

  assign w_unused = ^{clk, rst_n, i_take};

  always_comb begin
    o_win   = '0;
    o_id    = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_found && i_req[IDW'(i)]) begin
        o_win[IDW'(i)] = 1'b1;
        o_id           = IDW'(i);
        w_found        = 1'b1;
      end
    end
  end
`endif

  assign o_any = |i_req;

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares one SD sector-read engine among NREQ burst requesters and tags the byte stream.
// Arbitration policy selected by SD_ARB_ROUND_ROBIN_EN (round-robin) or fixed priority when undefined.
module sd_read_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 8,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   req_sector,
  input  logic [NREQ*CNTW-1:0] req_count,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 sd_rstart,
  output logic [31:0]          sd_rsector_no,
  input  logic                 sd_rbusy,
  input  logic                 sd_rdone,
  input  logic                 sd_outreq,
  input  logic [SD_ADDR_W-1:0] sd_outaddr,
  input  logic [7:0]           sd_outbyte,
  output logic                 o_valid,
  output logic [IDW-1:0]       o_id,
  output logic [CNTW-1:0]      o_idx,
  output logic [SD_ADDR_W-1:0] o_addr,
  output logic [7:0]           o_byte
);

  sd_arb_state_t        r_state;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      r_done;
  logic                 r_rstart;
  logic [31:0]          r_sector_no;
  logic [31:0]          r_base;
  logic [CNTW-1:0]      r_cnt;
  logic [CNTW-1:0]      r_idx;
  logic [IDW-1:0]       r_own;
  logic                 r_valid;
  logic [IDW-1:0]       r_oid;
  logic [CNTW-1:0]      r_oidx;
  logic [SD_ADDR_W-1:0] r_oaddr;
  logic [7:0]           r_obyte;

  logic [NREQ-1:0]      w_win;
  logic [IDW-1:0]       w_id;
  logic                 w_any;
  logic                 w_arb;
  logic                 w_fin;
  logic                 w_last;
  logic                 w_fwd;
  logic [31:0]          w_sel_sector;
  logic [CNTW-1:0]      w_sel_count;

  sd_arb_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (req),
    .i_take (w_arb),
    .o_win  (w_win),
    .o_id   (w_id),
    .o_any  (w_any)
  );

  // Requests are ignored while a done pulse is out so the finishing requester can drop req.
  assign w_arb = (r_state == ARB) && (r_gnt == '0) && (r_done == '0) && !sd_rbusy && w_any;

  assign w_sel_sector = req_sector[32*w_id +: 32];
  assign w_sel_count  = req_count[CNTW*w_id +: CNTW];

  assign w_fin  = ((r_state == WBUSY) && sd_rbusy && sd_rdone) ||
                  ((r_state == WDONE) && sd_rdone);
  assign w_last = ((r_idx + 1'b1) == r_cnt);
  assign w_fwd  = sd_outreq && ((r_state == WBUSY) || (r_state == WDONE));

  // The last-sector decision is taken on the rdone edge itself (not one cycle later in
  // NEXT) so done lands in D+1; NEXT only waits for the engine to go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB;
      r_gnt       <= '0;
      r_done      <= '0;
      r_rstart    <= 1'b0;
      r_sector_no <= '0;
      r_base      <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_own       <= '0;
      r_valid     <= 1'b0;
      r_oid       <= '0;
      r_oidx      <= '0;
      r_oaddr     <= '0;
      r_obyte     <= '0;
    end else begin
      r_done   <= '0;
      r_rstart <= 1'b0;
      r_valid  <= w_fwd;
      if (w_fwd) begin
        r_oid   <= r_own;
        r_oidx  <= r_idx;
        r_oaddr <= sd_outaddr;
        r_obyte <= sd_outbyte;
      end

      case (r_state)
        ARB: begin
          if (r_gnt != '0) begin
            // Zero-length burst granted last cycle: retire it without touching the engine.
            r_done <= r_gnt;
            r_gnt  <= '0;
          end else if (w_arb) begin
            r_gnt  <= w_win;
            r_own  <= w_id;
            r_base <= w_sel_sector;
            r_cnt  <= w_sel_count;
            r_idx  <= '0;
            if (w_sel_count != '0) begin
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_rstart    <= 1'b1;
          r_sector_no <= r_base + 32'(r_idx);
          r_state     <= WBUSY;
        end
        WBUSY: begin
          if (sd_rbusy && !sd_rdone) begin
            r_state <= WDONE;
          end
        end
        WDONE: begin
        end
        NEXT: begin
          if (!sd_rbusy) begin
            r_state <= ISSUE;
          end
        end
        default: begin
          r_state <= ARB;
        end
      endcase

      if (w_fin) begin
        if (w_last) begin
          r_done  <= r_gnt;
          r_gnt   <= '0;
          r_state <= ARB;
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_state <= NEXT;
        end
      end
    end
  end

  assign gnt           = r_gnt;
  assign done          = r_done;
  assign sd_rstart     = r_rstart;
  assign sd_rsector_no = r_sector_no;
  assign o_valid       = r_valid;
  assign o_id          = r_oid;
  assign o_idx         = r_oidx;
  assign o_addr        = r_oaddr;
  assign o_byte        = r_obyte;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Self-checking bench for sd_read_arbiter: table of single bursts plus hand-written
// sequences for engine init hold, multi-requester ordering and mid-burst reset.
module tb_sd_read_arbiter;

  localparam int NREQ = 4;
  localparam int CNTW = 8;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*32-1:0]   req_sector;
  logic [NREQ*CNTW-1:0] req_count;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 sd_rstart;
  logic [31:0]          sd_rsector_no;
  logic                 sd_rbusy;
  logic                 sd_rdone;
  logic                 sd_outreq;
  logic [8:0]           sd_outaddr;
  logic [7:0]           sd_outbyte;
  logic                 o_valid;
  logic [IDW-1:0]       o_id;
  logic [CNTW-1:0]      o_idx;
  logic [8:0]           o_addr;
  logic [7:0]           o_byte;

  sd_read_arbiter #(
    .NREQ (NREQ),
    .CNTW (CNTW),
    .IDW  (IDW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_sector    (req_sector),
    .req_count     (req_count),
    .gnt           (gnt),
    .done          (done),
    .sd_rstart     (sd_rstart),
    .sd_rsector_no (sd_rsector_no),
    .sd_rbusy      (sd_rbusy),
    .sd_rdone      (sd_rdone),
    .sd_outreq     (sd_outreq),
    .sd_outaddr    (sd_outaddr),
    .sd_outbyte    (sd_outbyte),
    .o_valid       (o_valid),
    .o_id          (o_id),
    .o_idx         (o_idx),
    .o_addr        (o_addr),
    .o_byte        (o_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i] && r < 0) r = i;
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] sec, input logic [8:0] a);
    return sec[7:0] ^ a[7:0] ^ {7'd0, a[8]} ^ 8'h5A;
  endfunction

  // Behavioural SD engine: accepts rstart, streams e_nbytes bytes, pulses rdone.
  logic        e_busy;
  logic        t_hold_busy;
  int          e_nbytes;
  int          e_ph;
  int          e_cnt;
  logic [31:0] e_sec;
  assign sd_rbusy = e_busy | t_hold_busy;

  initial begin
    e_busy = 1'b0; sd_rdone = 1'b0; sd_outreq = 1'b0; sd_outaddr = '0; sd_outbyte = '0;
    e_ph = 0; e_cnt = 0; e_sec = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        e_busy = 1'b0; sd_rdone = 1'b0; sd_outreq = 1'b0; e_ph = 0;
      end else begin
        case (e_ph)
          0: if (sd_rstart) begin
               e_busy = 1'b1; e_sec = sd_rsector_no; e_cnt = 0;
               if (e_nbytes == 0) begin sd_rdone = 1'b1; e_ph = 2; end
               else e_ph = 1;
             end
          1: if (e_cnt < e_nbytes) begin
               sd_outreq = 1'b1; sd_outaddr = 9'(e_cnt);
               sd_outbyte = exp_byte(e_sec, 9'(e_cnt)); e_cnt++;
             end else begin
               sd_outreq = 1'b0; sd_rdone = 1'b1; e_ph = 2;
             end
          default: begin sd_rdone = 1'b0; e_busy = 1'b0; e_ph = 0; end
        endcase
      end
    end
  end

  // Observation logs, sampled on the falling edge.
  logic [31:0] rs_q[$];
  int          g_q[$];
  int          d_q[$];
  int g_first, rs_first, done_cyc, last_rdone, have_rdone, min_gap;
  int gnt_cyc, beat_cnt, beat_bad, beat_addr, rs_since, cur_owner;
  logic [31:0] cur_sec;
  logic [NREQ-1:0] prev_gnt = '0;

  task automatic clear_logs();
    rs_q.delete(); g_q.delete(); d_q.delete();
    g_first = -1; rs_first = -1; done_cyc = -1; last_rdone = -1; have_rdone = 0;
    min_gap = 100000; gnt_cyc = 0; beat_cnt = 0; beat_bad = 0; beat_addr = 0;
    rs_since = 0; cur_owner = -1; cur_sec = '0;
  endtask

  always @(negedge clk) begin
    if (gnt != '0) begin
      gnt_cyc++;
      if (prev_gnt == '0) begin
        if (g_q.size() == 0) g_first = cyc;
        g_q.push_back(oh2id(gnt));
        cur_owner = oh2id(gnt);
        rs_since = 0;
      end
    end
    prev_gnt = gnt;
    if (sd_rstart) begin
      if (rs_q.size() == 0) rs_first = cyc;
      rs_q.push_back(sd_rsector_no);
      if (have_rdone != 0 && (cyc - last_rdone) < min_gap) min_gap = cyc - last_rdone;
      cur_sec = sd_rsector_no; beat_addr = 0; rs_since++;
    end
    if (sd_rdone) begin last_rdone = cyc; have_rdone = 1; end
    if (done != '0) begin d_q.push_back(oh2id(done)); done_cyc = cyc; end
    if (o_valid) begin
      beat_cnt++;
      if (int'(o_id) != cur_owner || int'(o_idx) != rs_since - 1 ||
          int'(o_addr) != beat_addr || o_byte != exp_byte(cur_sec, 9'(beat_addr)))
        beat_bad++;
      beat_addr++;
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] sector;
    logic [7:0]  count;
    logic [9:0]  nbytes;
    logic [1:0]  nstart;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [11:0] beats;
  } vec_t;

  task automatic run_row(input string tag, input vec_t v);
    int t0;
    bit got;
    @(negedge clk);
    clear_logs();
    e_nbytes = int'(v.nbytes);
    req_sector[32*v.id +: 32] = v.sector;
    req_count[CNTW*v.id +: CNTW] = v.count;
    req[v.id] = 1'b1;
    t0 = cyc;
    got = 1'b0;
    for (int n = 0; n < 6000 && !got; n++) begin
      @(negedge clk);
      if (done != '0) got = 1'b1;
    end
    req[v.id] = 1'b0;
    @(negedge clk);
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_done_n"}, 64'(d_q.size()), 64'd1);
    chk({tag, "_done_id"}, 64'(d_q.size() > 0 ? d_q[0] : -1), 64'(v.id));
    chk({tag, "_gnt_id"}, 64'(g_q.size() > 0 ? g_q[0] : -1), 64'(v.id));
    chk({tag, "_gnt_lat"}, 64'(g_first - t0), 64'd1);
    chk({tag, "_nstart"}, 64'(rs_q.size()), 64'(v.nstart));
    for (int k = 0; k < int'(v.nstart); k++)
      chk($sformatf("%s_sec%0d", tag, k), 64'(rs_q.size() > k ? rs_q[k] : 32'hDEAD_BEEF),
          64'(k == 0 ? v.s0 : (k == 1 ? v.s1 : v.s2)));
    chk({tag, "_beats"}, 64'(beat_cnt), 64'(v.beats));
    chk({tag, "_beat_bad"}, 64'(beat_bad), 64'd0);
    if (v.count == '0) begin
      chk({tag, "_gnt_cycles"}, 64'(gnt_cyc), 64'd1);
      chk({tag, "_done_lat"}, 64'(done_cyc - t0), 64'd2);
    end else begin
      chk({tag, "_start_lat"}, 64'(rs_first - t0), 64'd2);
      chk({tag, "_rdone_to_done"}, 64'(done_cyc - last_rdone), 64'd1);
      if (v.nstart > 2'd1) chk({tag, "_gap_ge2"}, 64'(min_gap >= 2), 64'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[5];
  vec_t post;
  int   exp_ord[5];
  int   ndone;
  bit   re;
  bit   seen;

  initial begin
    rst_n = 1'b0; req = '0; req_sector = '0; req_count = '0;
    t_hold_busy = 1'b0; e_nbytes = 4;
    clear_logs();

    tbl[0] = '{id:2'd0, sector:32'd100, count:8'd3, nbytes:10'd512, nstart:2'd3,
               s0:32'd100, s1:32'd101, s2:32'd102, beats:12'd1536};
    tbl[1] = '{id:2'd2, sector:32'd55, count:8'd0, nbytes:10'd512, nstart:2'd0,
               s0:32'd0, s1:32'd0, s2:32'd0, beats:12'd0};
    tbl[2] = '{id:2'd1, sector:32'hFFFF_FFFE, count:8'd3, nbytes:10'd4, nstart:2'd3,
               s0:32'hFFFF_FFFE, s1:32'hFFFF_FFFF, s2:32'h0000_0000, beats:12'd12};
    tbl[3] = '{id:2'd3, sector:32'd9, count:8'd1, nbytes:10'd0, nstart:2'd1,
               s0:32'd9, s1:32'd0, s2:32'd0, beats:12'd0};
    tbl[4] = '{id:2'd2, sector:32'h0000_1000, count:8'd2, nbytes:10'd1, nstart:2'd2,
               s0:32'h0000_1000, s1:32'h0000_1001, s2:32'd0, beats:12'd2};

    do_reset();
    @(negedge clk);
    chk("rst_gnt_done", 64'({gnt, done}), 64'd0);
    chk("rst_start_sec", 64'({sd_rstart, sd_rsector_no}), 64'd0);
    chk("rst_stream", 64'({o_valid, o_id, o_idx, o_addr, o_byte}), 64'd0);

    for (int r = 0; r < 5; r++) run_row($sformatf("row%0d", r), tbl[r]);

    // Engine still initialising after reset: no grant until sd_rbusy falls.
    t_hold_busy = 1'b1;
    do_reset();
    clear_logs();
    e_nbytes = 2;
    req_sector[32*1 +: 32] = 32'd5;
    req_count[CNTW*1 +: CNTW] = 8'd1;
    req[1] = 1'b1;
    repeat (5000) @(negedge clk);
    chk("init_no_gnt", 64'(gnt_cyc), 64'd0);
    t_hold_busy = 1'b0;
    @(negedge clk);
    chk("init_gnt1", 64'(gnt), 64'b0010);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (done != '0) seen = 1'b1;
    end
    req[1] = 1'b0;
    @(negedge clk);
    chk("init_done", 64'(d_q.size() > 0 ? d_q[0] : -1), 64'd1);
    chk("init_sec", 64'(rs_q.size() > 0 ? rs_q[0] : 32'hDEAD_BEEF), 64'd5);

    // All four requesters, count 1 each; req0 returns right after its done.
`ifdef SD_ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 0, 1, 2, 3};
`endif
    do_reset();
    clear_logs();
    e_nbytes = 2;
    for (int i = 0; i < NREQ; i++) begin
      req_sector[32*i +: 32] = 32'(10 + i);
      req_count[CNTW*i +: CNTW] = 8'd1;
    end
    @(negedge clk);
    req = '1;
    ndone = 0;
    re = 1'b0;
    for (int n = 0; n < 3000 && ndone < 5; n++) begin
      @(negedge clk);
      if (done != '0) begin
        req[oh2id(done)] = 1'b0;
        ndone++;
        if (oh2id(done) == 0 && !re) begin
          @(negedge clk);
          req[0] = 1'b1;
          re = 1'b1;
        end
      end
    end
    @(negedge clk);
    chk("rr_ndone", 64'(ndone), 64'd5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_gnt%0d", k), 64'(g_q.size() > k ? g_q[k] : -1), 64'(exp_ord[k]));
      chk($sformatf("rr_done%0d", k), 64'(d_q.size() > k ? d_q[k] : -1), 64'(exp_ord[k]));
    end

    // Reset asserted while a burst sits in WDONE.
    do_reset();
    clear_logs();
    e_nbytes = 512;
    req_sector[32*2 +: 32] = 32'h0000_0040;
    req_count[CNTW*2 +: CNTW] = 8'd2;
    @(negedge clk);
    req[2] = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    repeat (10) @(negedge clk);
    chk("mid_streaming", 64'(seen), 64'd1);
    chk("mid_pre_gnt", 64'(gnt), 64'b0100);
    chk("mid_pre_oid", 64'(o_id), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt_done", 64'({gnt, done, sd_rstart}), 64'd0);
    chk("mid_rst_sec", 64'(sd_rsector_no), 64'd0);
    chk("mid_rst_stream", 64'({o_valid, o_id, o_idx, o_addr, o_byte}), 64'd0);
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    post = '{id:2'd3, sector:32'h0000_0077, count:8'd1, nbytes:10'd2, nstart:2'd1,
             s0:32'h0000_0077, s1:32'd0, s2:32'd0, beats:12'd2};
    run_row("post_rst", post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_read_arbiter.md
# sd_read_arbiter

Shares one SD sector-read engine among NREQ requesters. Each requester asks for a burst of consecutive sectors. The arbiter grants one requester at a time and issues one sector read per `rstart`/`rdone` handshake. It forwards the engine's byte stream tagged with the owner's id and sector index. It sits between the SD reader and its clients, such as the file-system walker and the UART dump.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `CNTW`, 8: width of the burst sector count.
- `IDW`, $clog2(NREQ): width of the requester id.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: level request; must be held until the matching `done` pulse.
- `req_sector` in NREQ×32: first sector; sampled at grant.
- `req_count` in NREQ×CNTW: number of sectors; sampled at grant.
- `gnt` out NREQ: one-hot; held for the whole burst.
- `done` out NREQ: one-cycle pulse at burst end.
- `sd_rstart` out 1: read-start pulse to the engine.
- `sd_rsector_no` out 32: sector number for the current read.
- `sd_rbusy` in 1: engine busy, including card init.
- `sd_rdone` in 1: one-cycle pulse, sector complete.
- `sd_outreq`, `sd_outaddr`[8:0], `sd_outbyte`[7:0] in: byte stream from the engine.
- `o_valid` out 1: registered copy of `sd_outreq`.
- `o_id` out IDW: id of the owning requester.
- `o_idx` out CNTW: sector index within the burst, 0-based.
- `o_addr` out 9: byte address within the sector.
- `o_byte` out 8: data byte.

## Operation
- States: `ARB`, `ISSUE`, `WBUSY`, `WDONE`, `NEXT`.
- `ARB`:
  - If any `req` is asserted and `sd_rbusy`=0, pick the winner.
  - Assert `gnt[w]` and latch sector, count and id.
  - Clear `idx`.
  - If the latched count is 0, pulse `done[w]` in the next cycle without an engine access and return to `ARB`.
  - Otherwise go to `ISSUE`.
- `ISSUE`: drive `sd_rstart`=1 for exactly one cycle, with `sd_rsector_no` = latched sector + `idx`. Then go to `WBUSY`.
- `WBUSY`: wait for `sd_rbusy`=1, which is the engine's acceptance. Then go to `WDONE`.
- `WDONE`:
  - On `sd_rdone`, go to `NEXT`.
  - `sd_rdone` arriving in the same cycle as `sd_rbusy` rising in `WBUSY` counts as acceptance plus completion.
- `NEXT`:
  - If `idx`+1 == count, pulse `done[w]`, drop `gnt`, and return to `ARB`.
  - Otherwise increment `idx`, wait for `sd_rbusy`=0, then go to `ISSUE`.
- Sector arithmetic is 32-bit unsigned and wraps modulo 2^32; 0xFFFFFFFF+1 → 0.
- `idx` is CNTW bits wide; count is at most 2^CNTW−1.
- Stream forwarding is active only in `WBUSY` and `WDONE`.
  - `o_valid`=`sd_outreq` delayed one cycle.
  - `o_id`, `o_idx` come from the latched owner; `o_addr`/`o_byte` are registered `sd_outaddr`/`sd_outbyte`.
  - `sd_outreq` in any other state is dropped.
- A requester deasserting `req` mid-burst does not abort the burst. The burst completes and `done` still pulses.
- A requester may re-request in the cycle after its `done`. It is then arbitrated fairly per the configured policy.
- While the engine is initialising (`sd_rbusy`=1 from reset), `ARB` holds and no grant is issued.

## Timing
- Reset values:
  - `gnt`=0, `done`=0, `sd_rstart`=0, `sd_rsector_no`=0.
  - `o_valid`=0, `o_id`=0, `o_idx`=0, `o_addr`=0, `o_byte`=0.
  - State=`ARB`, round-robin pointer=0.
- `req` seen in cycle T with engine idle → `gnt` in T+1 → `sd_rstart` in T+2.
- `sd_rdone` in cycle D:
  - → `done` in D+1 for the last sector.
  - → `sd_rstart` no earlier than D+2, and only after `sd_rbusy`=0, for the next sector.
- All outputs are registered.
- Reset mid-burst clears everything immediately. The engine's own reset is external to this block.

## Configuration
- `SD_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration.
  - Search starts at the index after the last granted requester, wrapping NREQ−1→0.
  - The pointer updates at each grant.
- Not defined:
  - Fixed priority, lowest index wins.
  - No pointer register is built.

## Structure
- Package `sd_arb_pkg`:
  - State enum `sd_arb_state_t`.
  - Localparams `SD_SECTOR_BYTES`=512 and `SD_ADDR_W`=9.
- Sub-module `sd_arb_picker`:
  - Combinational one-hot selector over `req`.
  - Contains the round-robin pointer register when `SD_ARB_ROUND_ROBIN_EN` is defined.
  - Outputs one-hot winner and id.

## Test plan
- Single request, req0 with sector 100 and count 3:
  - `sd_rstart` pulses with 100, 101, 102.
  - 1536 `o_valid` beats with `o_id`=0 and `o_idx` 0..2.
  - One `done[0]` after the third `sd_rdone`.
- Count 0 on req2 → `gnt[2]` for one cycle, `done[2]` pulse, no `sd_rstart`.
- req0..3 all asserted, count 1 each, round-robin defined:
  - Grant order 0,1,2,3.
  - req0 re-asserted after its `done` is served after req3.
  - With the macro undefined, req0 wins again.
- Sector 0xFFFFFFFE, count 3 → `sd_rsector_no` = 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- `sd_rbusy` held 1 for 5000 cycles after reset with req1 asserted → no `gnt` until `sd_rbusy` falls, then `gnt[1]`.
- `rst_n` asserted mid-burst in `WDONE` → all outputs 0 in the same cycle; after release, the next `req` is granted normally.
